// File: rtl/ifetch.sv
// Instruction fetch stage: imem req/gnt/rvalid front end feeding an in-order buffer to decode.
// Optional build macro IFETCH_MISALIGN_EN adds the instr_fault output and misaligned-PC handling.
module ifetch #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] Iaddress,
  input  logic            flush,
  output logic            pc_advance,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
`ifdef IFETCH_MISALIGN_EN
  output logic            instr_fault,
`endif
  input  logic            instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
`ifdef IFETCH_MISALIGN_EN
  localparam logic [31:0] NOP = 32'h0000_0013;
`endif

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic [PW-1:0]   fhead_q, fhead_d, ftail_q, ftail_d;
  logic [PW-1:0]   phead_q, phead_d, ptail_q, ptail_d;
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [31:0]     fifo_instr_d [DEPTH];
  logic [XLEN-1:0] fifo_pc_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_d [DEPTH];
  logic [XLEN-1:0] pend_q [DEPTH];
  logic [XLEN-1:0] pend_d [DEPTH];
`ifdef IFETCH_MISALIGN_EN
  logic            fifo_flt_q [DEPTH];
  logic            fifo_flt_d [DEPTH];
`endif

  logic [CW:0]     occ;
  logic [XLEN-1:0] fetch_addr;
  logic            credit, misalign, run_ok, grant, resp, mis_push, push, pop;

  // Request side: credit check, address formation, accept/response qualifiers
  always_comb begin
    occ        = (CW+1)'(outst_q) + (CW+1)'(fcnt_q);
    credit     = occ < (CW+1)'(DEPTH);
`ifdef IFETCH_MISALIGN_EN
    misalign   = Iaddress[1:0] != 2'b00;
    fetch_addr = Iaddress;
`else
    misalign   = 1'b0;
    fetch_addr = Iaddress & ~XLEN'(3);
`endif
    run_ok     = !reset && (state_q == RUN) && !flush && credit;
    imem_req   = run_ok && !misalign;
    imem_addr  = fetch_addr;
    grant      = imem_req && imem_gnt;
    // A faulting entry must queue behind every fetch still in flight
    mis_push   = run_ok && misalign && (outst_q == '0);
    pc_advance = grant || mis_push;
    resp       = imem_rvalid && (state_q == RUN) && (outst_q != '0);
    push       = resp || mis_push;
    pop        = (fcnt_q != '0) && instr_ready;
  end

  // Next state: flush/drain bookkeeping, pending-PC queue and output FIFO
  always_comb begin
    state_d      = state_q;
    outst_d      = outst_q;
    discard_d    = discard_q;
    fcnt_d       = fcnt_q;
    fhead_d      = fhead_q;
    ftail_d      = ftail_q;
    phead_d      = phead_q;
    ptail_d      = ptail_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    pend_d       = pend_q;
`ifdef IFETCH_MISALIGN_EN
    fifo_flt_d   = fifo_flt_q;
`endif

    if (flush) begin
      outst_d = '0;
      fcnt_d  = '0;
      fhead_d = '0;
      ftail_d = '0;
      phead_d = '0;
      ptail_d = '0;
      // A response landing in the flush cycle retires one stale fetch immediately
      if (state_q == RUN) begin
        discard_d = outst_q + CW'(grant) - CW'(resp);
      end else if (imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      state_d = (discard_d != '0) ? DRAIN : RUN;
    end else if (state_q == DRAIN) begin
      if (imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (discard_d == '0) begin
        state_d = RUN;
      end
    end else begin
      if (grant) begin
        pend_d[ptail_q] = fetch_addr;
        ptail_d         = ptail_q + PW'(1);
      end
      if (resp) begin
        fifo_instr_d[ftail_q] = imem_rdata;
        fifo_pc_d[ftail_q]    = pend_q[phead_q];
`ifdef IFETCH_MISALIGN_EN
        fifo_flt_d[ftail_q]   = 1'b0;
`endif
        phead_d = phead_q + PW'(1);
      end
`ifdef IFETCH_MISALIGN_EN
      if (mis_push) begin
        fifo_instr_d[ftail_q] = NOP;
        fifo_pc_d[ftail_q]    = Iaddress;
        fifo_flt_d[ftail_q]   = 1'b1;
      end
`endif
      if (push) begin
        ftail_d = ftail_q + PW'(1);
      end
      if (pop) begin
        fhead_d = fhead_q + PW'(1);
      end
      outst_d = outst_q + CW'(grant) - CW'(resp);
      fcnt_d  = fcnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      outst_q      <= '0;
      discard_q    <= '0;
      fcnt_q       <= '0;
      fhead_q      <= '0;
      ftail_q      <= '0;
      phead_q      <= '0;
      ptail_q      <= '0;
      fifo_instr_q <= '{default: '0};
      fifo_pc_q    <= '{default: '0};
      pend_q       <= '{default: '0};
`ifdef IFETCH_MISALIGN_EN
      fifo_flt_q   <= '{default: 1'b0};
`endif
    end else begin
      state_q      <= state_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      fcnt_q       <= fcnt_d;
      fhead_q      <= fhead_d;
      ftail_q      <= ftail_d;
      phead_q      <= phead_d;
      ptail_q      <= ptail_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
      pend_q       <= pend_d;
`ifdef IFETCH_MISALIGN_EN
      fifo_flt_q   <= fifo_flt_d;
`endif
    end
  end

  // Decode side sees only the FIFO head registers
  assign instr_valid = fcnt_q != '0;
  assign instr       = fifo_instr_q[fhead_q];
  assign instr_pc    = fifo_pc_q[fhead_q];
`ifdef IFETCH_MISALIGN_EN
  assign instr_fault = fifo_flt_q[fhead_q];
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && imem_rvalid && (state_q == RUN)) begin
      assert (outst_q != '0) else $error("ifetch: imem_rvalid with no fetch outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a directed vector table, hand-built full/flush sequences and a randomized
// run against a queue-based reference of the fetch stream.
`timescale 1ns/1ps
module tb_ifetch;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset, flush, imem_gnt, imem_rvalid, instr_ready;
  logic [XLEN-1:0] Iaddress, imem_addr, instr_pc;
  logic [31:0]     imem_rdata, instr;
  logic            pc_advance, imem_req, instr_valid;
`ifdef IFETCH_MISALIGN_EN
  logic            instr_fault;
`endif

  ifetch #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Iaddress(Iaddress), .flush(flush),
    .pc_advance(pc_advance), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
`ifdef IFETCH_MISALIGN_EN
    .instr_fault(instr_fault),
`endif
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Directed table: one row per clock cycle
  typedef struct {
    logic        rst, fl, gnt, rv, rdy;
    logic [31:0] ia, rd;
    logic        e_req, e_adv, e_val;
    logic [31:0] e_addr, e_instr, e_pc;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(input logic rst, input logic fl, input logic [31:0] ia,
                              input logic gnt, input logic rv, input logic [31:0] rd,
                              input logic rdy, input logic e_req, input logic e_adv,
                              input logic [31:0] e_addr, input logic e_val,
                              input logic [31:0] e_instr, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.ia = ia; v.gnt = gnt; v.rv = rv; v.rd = rd; v.rdy = rdy;
    v.e_req = e_req; v.e_adv = e_adv; v.e_addr = e_addr;
    v.e_val = e_val; v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  // Reference state: memory side and expected fetch stream
  int unsigned gnt_pct, rv_pct, rdy_pct;
  int unsigned cyc_n = 0;
  int          n_grant;
  int          stale;
  logic [31:0] pc;
  logic [31:0] mem_a [$];
  int unsigned mem_t [$];
  logic [31:0] live [$];
  logic [31:0] oq_i [$];
  logic [31:0] oq_pc [$];
  logic [31:0] dut_pop [$];

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    logic [31:0] r;
    r = (a << 8) ^ 32'h5A00_0013;
    return r;
  endfunction

  task automatic clear_model(input logic [31:0] start);
    mem_a.delete(); mem_t.delete(); live.delete();
    oq_i.delete(); oq_pc.delete(); dut_pop.delete();
    stale = 0; n_grant = 0; pc = start;
  endtask

  task automatic do_reset(input logic [31:0] start);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1; flush = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
      imem_rdata = 32'h0; instr_ready = 1'b1; Iaddress = start;
      #1;
      chk("rst.req", 64'(imem_req), 64'(1'b0));
      chk("rst.adv", 64'(pc_advance), 64'(1'b0));
      if (i == 1) chk("rst.valid", 64'(instr_valid), 64'(1'b0));
    end
    clear_model(start);
  endtask

  // One cycle driven by the memory/decode/PC stand-ins and checked against the reference
  task automatic run_cycle(input logic fl, input logic [31:0] tgt);
    logic       ex_req, ex_val;
    logic [1:0] lo;
    logic [31:0] p;
    @(negedge clk);
    lo = 2'b00;
`ifndef IFETCH_MISALIGN_EN
    lo = 2'($urandom_range(3));
`endif
    reset       = 1'b0;
    flush       = fl;
    Iaddress    = pc | {30'b0, lo};
    instr_ready = $urandom_range(99) < rdy_pct;
    imem_gnt    = $urandom_range(99) < gnt_pct;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_a.size() > 0 && mem_t[0] < cyc_n && $urandom_range(99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = rdata_of(mem_a.pop_front());
      void'(mem_t.pop_front());
    end
    #1;
    ex_req = (stale == 0) && !fl && ((live.size() + oq_i.size()) < int'(DEPTH));
    ex_val = oq_i.size() > 0;
    chk("rnd.req", 64'(imem_req), 64'(ex_req));
    chk("rnd.adv", 64'(pc_advance), 64'(ex_req && imem_gnt));
    if (ex_req) chk("rnd.addr", 64'(imem_addr), 64'(pc));
    chk("rnd.valid", 64'(instr_valid), 64'(ex_val));
    if (ex_val) begin
      chk("rnd.instr", 64'(instr), 64'(oq_i[0]));
      chk("rnd.pc", 64'(instr_pc), 64'(oq_pc[0]));
`ifdef IFETCH_MISALIGN_EN
      chk("rnd.fault", 64'(instr_fault), 64'(1'b0));
`endif
    end
    if (instr_valid && instr_ready) dut_pop.push_back(instr_pc);
    if (imem_req && imem_gnt) begin
      mem_a.push_back(imem_addr);
      mem_t.push_back(cyc_n);
      n_grant++;
    end
    if (ex_val && instr_ready && !fl) begin
      void'(oq_i.pop_front());
      void'(oq_pc.pop_front());
    end
    if (fl) begin
      stale += live.size();
      live.delete(); oq_i.delete(); oq_pc.delete();
    end
    if (imem_rvalid) begin
      if (stale > 0) stale--;
      else if (live.size() > 0) begin
        p = live.pop_front();
        oq_i.push_back(rdata_of(p));
        oq_pc.push_back(p);
      end
    end
    if (ex_req && imem_gnt) live.push_back(pc);
    cyc_n++;
    if (fl) pc = tgt;
    else if (pc_advance) pc = pc + 32'd4;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    int g0;
    logic fl;
    reset = 1'b1; flush = 1'b0; Iaddress = 32'h100; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;

    do_reset(32'h100);

    // rst fl  ia      gnt rv rdata          rdy  req adv addr     val instr          pc
    tbl[0]  = mk(1, 0, 32'h100, 1, 0, 32'h0,        1, 0, 0, 32'h0,   0, 32'h0,        32'h0);
    tbl[1]  = mk(1, 0, 32'h100, 1, 0, 32'h0,        1, 0, 0, 32'h0,   0, 32'h0,        32'h0);
    tbl[2]  = mk(0, 0, 32'h100, 1, 0, 32'h0,        1, 1, 1, 32'h100, 0, 32'h0,        32'h0);
    tbl[3]  = mk(0, 0, 32'h104, 1, 1, 32'h00500093, 1, 1, 1, 32'h104, 0, 32'h0,        32'h0);
    tbl[4]  = mk(0, 0, 32'h108, 1, 1, 32'h11111113, 1, 0, 0, 32'h0,   1, 32'h00500093, 32'h100);
    tbl[5]  = mk(0, 0, 32'h108, 1, 0, 32'h0,        1, 1, 1, 32'h108, 1, 32'h11111113, 32'h104);
    tbl[6]  = mk(0, 0, 32'h10C, 0, 1, 32'h22222213, 0, 1, 0, 32'h10C, 0, 32'h0,        32'h0);
    tbl[7]  = mk(0, 0, 32'h10C, 0, 0, 32'h0,        0, 1, 0, 32'h10C, 1, 32'h22222213, 32'h108);
    tbl[8]  = mk(0, 0, 32'h10C, 0, 0, 32'h0,        0, 1, 0, 32'h10C, 1, 32'h22222213, 32'h108);
    tbl[9]  = mk(0, 0, 32'h10C, 0, 0, 32'h0,        1, 1, 0, 32'h10C, 1, 32'h22222213, 32'h108);
    tbl[10] = mk(0, 0, 32'h10C, 0, 0, 32'h0,        1, 1, 0, 32'h10C, 0, 32'h0,        32'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      reset = tbl[i].rst; flush = tbl[i].fl; Iaddress = tbl[i].ia;
      imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rd;
      instr_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d.req", i), 64'(imem_req), 64'(tbl[i].e_req));
      chk($sformatf("tbl%0d.adv", i), 64'(pc_advance), 64'(tbl[i].e_adv));
      if (tbl[i].e_req) chk($sformatf("tbl%0d.addr", i), 64'(imem_addr), 64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d.valid", i), 64'(instr_valid), 64'(tbl[i].e_val));
      if (tbl[i].e_val) begin
        chk($sformatf("tbl%0d.instr", i), 64'(instr), 64'(tbl[i].e_instr));
        chk($sformatf("tbl%0d.pc", i), 64'(instr_pc), 64'(tbl[i].e_pc));
      end
    end

    // Full buffer with decode stalled: exactly DEPTH grants, then in-order drain
    do_reset(32'h100);
    gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 32'h0);
    chk("full.grants", 64'(n_grant), 64'(DEPTH));
    rdy_pct = 100;
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0);
    chk("full.npop", 64'(dut_pop.size() >= 2), 64'(1'b1));
    if (dut_pop.size() >= 2) begin
      chk("full.pop0", 64'(dut_pop[0]), 64'(32'h100));
      chk("full.pop1", 64'(dut_pop[1]), 64'(32'h104));
    end

    // Flush with two fetches outstanding: both responses dropped, refetch from target
    do_reset(32'h100);
    gnt_pct = 100; rv_pct = 0; rdy_pct = 100;
    run_cycle(1'b0, 32'h0);
    run_cycle(1'b0, 32'h0);
    chk("flush.outst", 64'(n_grant), 64'(2));
    run_cycle(1'b1, 32'h200);
    rv_pct = 100;
    dut_pop.delete();
    g0 = n_grant;
    run_cycle(1'b0, 32'h0);
    run_cycle(1'b0, 32'h0);
    chk("flush.drain_noreq", 64'(n_grant - g0), 64'(0));
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 32'h0);
    chk("flush.npop", 64'(dut_pop.size() >= 1), 64'(1'b1));
    if (dut_pop.size() >= 1) chk("flush.pc", 64'(dut_pop[0]), 64'(32'h200));

    // Randomized traffic with occasional redirects and a mid-run reset
    for (int seg = 0; seg < 2; seg++) begin
      do_reset(32'h1000 * (seg + 1));
      gnt_pct = 60; rv_pct = 50; rdy_pct = 70;
      for (int i = 0; i < 400; i++) begin
        fl = $urandom_range(99) < 4;
        run_cycle(fl, 32'($urandom_range(16'hFFFF)) << 2);
      end
    end

`ifdef IFETCH_MISALIGN_EN
    // Misaligned PC: no memory request, faulting NOP entry delivered instead
    do_reset(32'h100);
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; Iaddress = 32'h102; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; instr_ready = 1'b0;
    #1;
    chk("mis.req", 64'(imem_req), 64'(1'b0));
    chk("mis.adv", 64'(pc_advance), 64'(1'b1));
    @(negedge clk);
    Iaddress = 32'h106; imem_gnt = 1'b0;
    #1;
    chk("mis.valid", 64'(instr_valid), 64'(1'b1));
    chk("mis.instr", 64'(instr), 64'(32'h0000_0013));
    chk("mis.fault", 64'(instr_fault), 64'(1'b1));
    chk("mis.pc", 64'(instr_pc), 64'(32'h102));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
